regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters.
REQ-002 Parameter AW, default 3: register index width (8 registers).
REQ-003 Parameter DW, default 16: register data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester write request.
REQ-007 req_addr  input  NREQ*AW  per-requester target register index, requester i in bits [i*AW +: AW].
REQ-008 req_data  input  NREQ*DW  per-requester write data, requester i in bits [i*DW +: DW].
REQ-009 req_ready  output  NREQ  one-hot-or-zero grant; a transfer completes when req_valid[i] and req_ready[i] are both 1.
REQ-010 clear_req  input  1  pulse or level; requests a sequenced zero-fill of all registers.
REQ-011 clear_busy  output  1  high while the clear sequence owns the write port.
REQ-012 clear_done  output  1  one-cycle pulse when the clear sequence finishes.
REQ-013 WriteEn  output  1  register-file write enable.
REQ-014 WriteReg  output  AW  register-file write index.
REQ-015 WriteData  output  DW  register-file write data.

Function
REQ-016 States: ARB (arbitrate requesters) and CLEAR (zero-fill); no other states.
REQ-017 In ARB with clear_req=0, req_ready is combinational: the first i with req_valid[i]=1, searching upward from rr_ptr and wrapping modulo NREQ, gets req_ready[i]=1; all others 0.
REQ-018 In ARB, req_ready=0 for all requesters when no req_valid is set.
REQ-019 On a completed transfer by requester g, rr_ptr becomes (g+1) mod NREQ on the next edge; otherwise rr_ptr holds.
REQ-020 Write latency is one cycle: the cycle after a transfer, WriteEn=1, WriteReg=req_addr[g], WriteData=req_data[g] as sampled at the transfer edge.
REQ-021 WriteEn=0 in any cycle following a cycle with no transfer and no clear write; WriteReg and WriteData hold their last values while WriteEn=0.
REQ-022 Sustained throughput is one write per cycle; a requester held valid may be granted on consecutive cycles only when no other requester is valid.
REQ-023 In ARB with clear_req=1: all req_ready=0 that cycle, and the state moves to CLEAR with clear index 0 on the next edge; clear has priority over requesters.
REQ-024 In CLEAR: req_ready=0, clear_busy=1, WriteEn=1, WriteReg=clear index, WriteData=0; the index increments each cycle from 0 to 2^AW-1 (8 cycles).
REQ-025 On the edge after the index reaches 2^AW-1: state becomes ARB, clear_busy=0, clear_done=1 for exactly one cycle; rr_ptr is unchanged by the clear.
REQ-026 clear_req asserted during CLEAR is ignored and does not restart or extend the sequence; clear_req still high on return to ARB starts a new clear.
REQ-027 Duplicate target indices from different requesters need no special handling; writes land in grant order and the last write wins.

Reset
REQ-028 While rst=0 at a rising edge: state=ARB, rr_ptr=0, clear index=0, WriteEn=0, WriteReg=0, WriteData=0, clear_busy=0, clear_done=0.
REQ-029 req_ready=0 for all requesters in any cycle where rst=0.
REQ-030 Reset during CLEAR aborts the sequence with no clear_done pulse; a write already presented in that cycle is not suppressed retroactively.

Structure
REQ-031 Default AW and DW values, the register count (2^AW) and the state encoding belong in the shared package used with the register file.
REQ-032 The wrap-around priority pick is one sub-module, rr_pick (inputs: request vector, pointer; output: one-hot grant).
REQ-033 The write-port outputs are registered; req_ready is the only combinational output.

Verification
REQ-034 Reset: rst=0 for 2 cycles with all req_valid=1 -> req_ready=0000, WriteEn=0, clear_busy=0 throughout.
REQ-035 Round-robin: req_valid=1111 held, req_addr[i]=i, req_data[i]=0x1000+i -> grants 0,1,2,3,0; one cycle later writes (1,0x1001) after (0,0x1000), one write per cycle.
REQ-036 Pointer wrap: rr_ptr=3 after a grant to requester 2, then req_valid=0011 -> grant to requester 0, then requester 1.
REQ-037 Clear: one-cycle clear_req in ARB while req_valid=0001 -> 8 cycles of WriteEn=1, WriteReg 0..7, WriteData=0x0000, req_ready=0000; then clear_done pulses once and requester 0 is granted.
REQ-038 Clear re-request: clear_req held high from clear index 3 onward -> sequence ends at index 7, clear_done pulses, and a new clear starts at the next edge without granting requesters.
REQ-039 Reset mid-clear: rst=0 at clear index 5 -> state=ARB, WriteEn=0 next cycle, no clear_done pulse.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and the register file
// it feeds: default index/data widths, register count and arbiter state encoding.
package regfile_write_arbiter_pkg;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 16;
  localparam int NREGS  = 2 ** DEF_AW;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Wrap-around priority pick: grants the first set bit of req searching upward
// from ptr and wrapping modulo N.
//   req   : request vector
//   ptr   : index with highest priority
//   grant : one-hot (or zero) grant
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
  assign rot   = (req >> ptr) | (req << (N - int'(ptr)));
  assign first = rot & (~rot + N'(1));
  assign grant = (first << ptr) | (first >> (N - int'(ptr)));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a register file with a sequenced
// zero-fill (clear) that takes priority over all requesters.
//   clk, rst            : clock, synchronous active-low reset
//   req_valid/addr/data : per-requester write requests (packed by requester)
//   req_ready           : combinational one-hot-or-zero grant
//   clear_req           : request a zero-fill of every register
//   clear_busy          : clear sequence owns the write port
//   clear_done          : one-cycle pulse at the end of a clear
//   WriteEn/Reg/Data    : registered register-file write port
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             WriteEn,
  output logic [AW-1:0]    WriteReg,
  output logic [DW-1:0]    WriteData
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;

  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] fire;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick)
  );

  assign req_ready  = (rst && (state_q == ST_ARB) && !clear_req) ? pick : '0;
  assign fire       = req_valid & req_ready;
  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
  assign WriteEn    = we_q;
  assign WriteReg   = wreg_q;
  assign WriteData  = wdata_q;

  // The write port is registered, so the clear's first write (index 0) is
  // loaded on the ARB->CLEAR edge and each later index one edge ahead.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_idx_d = clr_idx_q;
    we_d      = 1'b0;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
          we_d      = 1'b1;
          wreg_d    = '0;
          wdata_d   = '0;
        end else begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (fire[i]) begin
              we_d     = 1'b1;
              wreg_d   = req_addr[i*AW +: AW];
              wdata_d  = req_data[i*DW +: DW];
              rr_ptr_d = PW'((i + 1) % NREQ);
            end
          end
        end
      end
      ST_CLEAR: begin
        if (clr_idx_q == '1) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
          we_d      = 1'b1;
          wreg_d    = clr_idx_q + AW'(1);
          wdata_d   = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      clr_idx_q <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_idx_q <= clr_idx_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

endmodule
